// File: rtl/mem_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// mem_arbiter_ctrl
// Memory manager between the CPU core and the external memory bus. Arbitrates an
// instruction-fetch port (read-only) and a data port (read/write, byte-enabled)
// onto one bus master. Each transaction runs IDLE -> ISSUE -> (WAIT_RSP) -> RESP.
// The winning port receives a one-cycle ack in RESP, plus read data for loads.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : WAIT_RSP gives up after TIMEOUT_CYC cycles without bus_rvalid,
//               completes with err=1 and zeroed read data.
//   undefined : WAIT_RSP waits indefinitely and err is tied low.
//
// Ports
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   instr_req/addr              fetch request (held until instr_ack) and address
//   instr_rdata/ack             fetch data and one-cycle completion pulse
//   data_read/write/addr/wdata/be  load/store request (held until data_ack)
//   data_rdata/ack              load data and one-cycle completion pulse
//   bus_addr/wdata/be           registered request fields driven to the bus
//   bus_read/bus_write          request strobes, high only in ISSUE
//   bus_full                    bus back-pressure; accept = strobe && !bus_full
//   bus_rdata/bus_rvalid        read response from the bus
//   state                       FSM state: IDLE=0 ISSUE=1 WAIT_RSP=2 RESP=3
//   err                         timeout flag, valid with the ack
// -----------------------------------------------------------------------------
module mem_arbiter_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_req,
  input  logic [ADDR_W-1:0]   instr_addr,
  output logic [DATA_W-1:0]   instr_rdata,
  output logic                instr_ack,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_be,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_ack,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  output logic                bus_read,
  output logic                bus_write,
  input  logic                bus_full,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_rvalid,
  output logic [2:0]          state,
  output logic                err
);

  localparam int BE_W = DATA_W / 8;
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_RSP = 3'd2,
    RESP     = 3'd3
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_instr_q;   // 1: current transaction belongs to the fetch port
  logic              is_write_q;
  logic [SC_W-1:0]   starve_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [BE_W-1:0]   bus_be_q;
  logic [DATA_W-1:0] instr_rdata_q, data_rdata_q;

  logic data_req, instr_forced, pick_data, pick_instr, grant, timeout_hit;

  // Data normally wins; once data has taken STARVE_MAX grants in a row while a
  // fetch waited, the fetch is forced through.
  always_comb begin
    data_req     = data_read | data_write;
    instr_forced = instr_req && (starve_q == SC_W'(STARVE_MAX));
    pick_data    = data_req && !instr_forced;
    pick_instr   = instr_req && !pick_data;
    grant        = (state_q == IDLE) && (pick_data || pick_instr);
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;

  // A response arriving on the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state_q == WAIT_RSP) && !bus_rvalid &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == WAIT_RSP) to_cnt_q <= to_cnt_q + TO_W'(1);
      else                     to_cnt_q <= '0;
      if (grant)            err_q <= 1'b0;
      else if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign err = (state_q == RESP) && err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (pick_data || pick_instr) state_d = ISSUE;
      ISSUE:    if (!bus_full) state_d = is_write_q ? RESP : WAIT_RSP;
      WAIT_RSP: if (bus_rvalid || timeout_hit) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Request capture, starvation tracking and response latching
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_instr_q   <= 1'b0;
      is_write_q    <= 1'b0;
      starve_q      <= '0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_be_q      <= '0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      if (grant) begin
        gnt_instr_q <= pick_instr;
        // A simultaneous read and write is a read.
        is_write_q  <= pick_data && !data_read;
        bus_addr_q  <= pick_instr ? instr_addr : data_addr;
        if (pick_data && !data_read) begin
          bus_wdata_q <= data_wdata;
          bus_be_q    <= data_be;
        end else begin
          bus_be_q    <= '1;
        end
      end

      if (!instr_req || (grant && pick_instr))
        starve_q <= '0;
      else if (grant && pick_data && (starve_q != SC_W'(STARVE_MAX)))
        starve_q <= starve_q + SC_W'(1);

      if ((state_q == WAIT_RSP) && bus_rvalid) begin
        if (gnt_instr_q) instr_rdata_q <= bus_rdata;
        else             data_rdata_q  <= bus_rdata;
      end else if (timeout_hit) begin
        if (gnt_instr_q) instr_rdata_q <= '0;
        else             data_rdata_q  <= '0;
      end
    end
  end

  assign state       = state_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_be      = bus_be_q;
  assign bus_read    = (state_q == ISSUE) && !is_write_q;
  assign bus_write   = (state_q == ISSUE) && is_write_q;
  assign instr_ack   = (state_q == RESP) && gnt_instr_q;
  assign data_ack    = (state_q == RESP) && !gnt_instr_q;
  assign instr_rdata = instr_rdata_q;
  assign data_rdata  = data_rdata_q;

endmodule
